// File: rtl/pong_pkg.sv
// Shared types for the Pong game-flow sequencer: FSM state encoding and winner codes.
package pong_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SERVE    = 3'd1,
        PLAY     = 3'd2,
        POINT    = 3'd3,
        WIN_HOLD = 3'd4,
        PAUSED   = 3'd5
    } game_state_t;

    localparam logic [1:0] WINNER_NONE = 2'b00;
    localparam logic [1:0] WINNER_P1   = 2'b01;
    localparam logic [1:0] WINNER_P2   = 2'b10;

    localparam int HOLD_W = 32;

endpackage

// File: rtl/game_sequencer_tick_divider.sv
// Free-running base tick generator: counts 0..DIV-1 and pulses base_tick on DIV-1.
// DIV = CLOCK_FREQ / TICK_RATE must be at least 2.
module tick_divider #(
    parameter int CLOCK_FREQ = 50000000,
    parameter int TICK_RATE  = 50
) (
    input  logic clock,
    input  logic reset_n,
    output logic base_tick
);

    localparam logic [31:0] DIV = 32'(CLOCK_FREQ / TICK_RATE);

    logic [31:0] cnt_q, cnt_d;

    // Never gated: pause and win-hold must keep the tick phase intact.
    always_comb begin
        base_tick = (cnt_q == DIV - 32'd1);
        cnt_d     = base_tick ? 32'd0 : cnt_q + 32'd1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) cnt_q <= 32'd0;
        else          cnt_q <= cnt_d;
    end

endmodule

// File: rtl/game_sequencer.sv
// Pong game-flow sequencer: serve/play/point/win-hold/pause FSM driving game_tick and reset pulses.
// Define GAME_FRAME_SYNC_EN to defer each game_tick in PLAY until the next frame_end.
module game_sequencer
    import pong_pkg::*;
#(
    parameter int CLOCK_FREQ     = 50000000,
    parameter int TICK_RATE      = 50,
    parameter int SERVE_TICKS    = 50,
    parameter int WIN_HOLD_TICKS = 350
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       pause,
    input  logic       p1_scored,
    input  logic       p2_scored,
    input  logic       p1_wins,
    input  logic       p2_wins,
    input  logic       frame_end,
    output logic       game_tick,
    output logic       round_reset,
    output logic       match_reset,
    output logic [2:0] game_state,
    output logic [1:0] winner
);

    localparam logic [HOLD_W-1:0] SERVE_LD = HOLD_W'(SERVE_TICKS);
    localparam logic [HOLD_W-1:0] WIN_LD   = HOLD_W'(WIN_HOLD_TICKS);

    logic base_tick;

    tick_divider #(
        .CLOCK_FREQ (CLOCK_FREQ),
        .TICK_RATE  (TICK_RATE)
    ) u_tick_divider (
        .clock      (clock),
        .reset_n    (reset_n),
        .base_tick  (base_tick)
    );

    game_state_t       state_q, state_d;
    game_state_t       origin_q, origin_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [1:0]        winner_q, winner_d;
    logic [1:0]        scorer_q, scorer_d;
    logic              game_tick_q, game_tick_d;
    logic              round_reset_q, round_reset_d;
    logic              match_reset_q, match_reset_d;
    logic              pause_meta_q, pause_meta_d;
    logic              pause_sync_q, pause_sync_d;
`ifdef GAME_FRAME_SYNC_EN
    logic              tick_pend_q, tick_pend_d;
`else
    logic              unused_frame_end;
    assign unused_frame_end = frame_end;
`endif

    // Last scorer is kept for debug visibility only; the winner comes from the win levels.
    logic unused_scorer;
    assign unused_scorer = ^scorer_q;

    always_comb begin
        state_d       = state_q;
        origin_d      = origin_q;
        hold_d        = hold_q;
        winner_d      = winner_q;
        scorer_d      = scorer_q;
        game_tick_d   = 1'b0;
        round_reset_d = 1'b0;
        match_reset_d = 1'b0;
        pause_meta_d  = pause;
        pause_sync_d  = pause_meta_q;
`ifdef GAME_FRAME_SYNC_EN
        tick_pend_d   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                state_d       = SERVE;
                hold_d        = SERVE_LD;
                round_reset_d = 1'b1;
                match_reset_d = 1'b1;
            end
            SERVE: begin
                // Pause is checked first so a coincident base tick is dropped.
                if (pause_sync_q) begin
                    origin_d = SERVE;
                    state_d  = PAUSED;
                end else if (hold_q == '0) begin
                    state_d = PLAY;
                end else if (base_tick) begin
                    hold_d = hold_q - 1'b1;
                end
            end
            PLAY: begin
                if (p1_scored || p2_scored) begin
                    state_d  = POINT;
                    scorer_d = p1_scored ? WINNER_P1 : WINNER_P2;
                end else if (pause_sync_q) begin
                    origin_d = PLAY;
                    state_d  = PAUSED;
                end else begin
`ifdef GAME_FRAME_SYNC_EN
                    if (frame_end && tick_pend_q) begin
                        game_tick_d = 1'b1;
                        tick_pend_d = base_tick;
                    end else begin
                        tick_pend_d = tick_pend_q | base_tick;
                    end
`else
                    game_tick_d = base_tick;
`endif
                end
            end
            POINT: begin
                if (p1_wins || p2_wins) begin
                    winner_d = p1_wins ? WINNER_P1 : WINNER_P2;
                    hold_d   = WIN_LD;
                    state_d  = WIN_HOLD;
                end else begin
                    round_reset_d = 1'b1;
                    hold_d        = SERVE_LD;
                    state_d       = SERVE;
                end
            end
            WIN_HOLD: begin
                if (hold_q == '0) begin
                    match_reset_d = 1'b1;
                    round_reset_d = 1'b1;
                    winner_d      = WINNER_NONE;
                    hold_d        = SERVE_LD;
                    state_d       = SERVE;
                end else if (base_tick) begin
                    hold_d = hold_q - 1'b1;
                end
            end
            PAUSED: begin
                if (!pause_sync_q) state_d = origin_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            origin_q      <= IDLE;
            hold_q        <= '0;
            winner_q      <= WINNER_NONE;
            scorer_q      <= WINNER_NONE;
            game_tick_q   <= 1'b0;
            round_reset_q <= 1'b0;
            match_reset_q <= 1'b0;
            pause_meta_q  <= 1'b0;
            pause_sync_q  <= 1'b0;
`ifdef GAME_FRAME_SYNC_EN
            tick_pend_q   <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            origin_q      <= origin_d;
            hold_q        <= hold_d;
            winner_q      <= winner_d;
            scorer_q      <= scorer_d;
            game_tick_q   <= game_tick_d;
            round_reset_q <= round_reset_d;
            match_reset_q <= match_reset_d;
            pause_meta_q  <= pause_meta_d;
            pause_sync_q  <= pause_sync_d;
`ifdef GAME_FRAME_SYNC_EN
            tick_pend_q   <= tick_pend_d;
`endif
        end
    end

    assign game_tick   = game_tick_q;
    assign round_reset = round_reset_q;
    assign match_reset = match_reset_q;
    assign game_state  = state_q;
    assign winner      = winner_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed vector table, frame-sync sequence, random run vs. reference model.
module tb_game_sequencer;

    localparam int DIV = 10;
    localparam int SRV = 2;
    localparam int WH  = 3;

    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic       pause = 1'b0, p1_scored = 1'b0, p2_scored = 1'b0;
    logic       p1_wins = 1'b0, p2_wins = 1'b0, frame_end = 1'b0;
    logic       game_tick, round_reset, match_reset;
    logic [2:0] game_state;
    logic [1:0] winner;

    int checks = 0;
    int failures = 0;

    game_sequencer #(
        .CLOCK_FREQ(100), .TICK_RATE(10), .SERVE_TICKS(SRV), .WIN_HOLD_TICKS(WH)
    ) dut (
        .clock(clock), .reset_n(reset_n), .pause(pause),
        .p1_scored(p1_scored), .p2_scored(p2_scored),
        .p1_wins(p1_wins), .p2_wins(p2_wins), .frame_end(frame_end),
        .game_tick(game_tick), .round_reset(round_reset), .match_reset(match_reset),
        .game_state(game_state), .winner(winner)
    );

    always #5 clock = ~clock;

    // Reference model: states as integers 0..5, divider phase from an edge count.
    int m_cyc, m_st, m_org, m_hold, m_win, e_tick, e_rr, e_mr;
    bit m_pend, ph0, ph1;

    task automatic model_reset();
        m_cyc = 0; m_st = 0; m_org = 0; m_hold = 0; m_win = 0;
        e_tick = 0; e_rr = 0; e_mr = 0; m_pend = 0; ph0 = 0; ph1 = 0;
    endtask

    task automatic model_edge();
        bit bt, ps;
        bt = ((m_cyc % DIV) == DIV - 1);
        m_cyc++;
        ps = ph1; ph1 = ph0; ph0 = pause;
        e_tick = 0; e_rr = 0; e_mr = 0;
        case (m_st)
            0: begin m_st = 1; m_hold = SRV; e_rr = 1; e_mr = 1; end
            1: if (ps) begin m_org = 1; m_st = 5; end
               else if (m_hold == 0) m_st = 2;
               else if (bt) m_hold--;
            2: if (p1_scored || p2_scored) m_st = 3;
               else if (ps) begin m_org = 2; m_st = 5; end
               else begin
`ifdef GAME_FRAME_SYNC_EN
                   if (frame_end && m_pend) begin e_tick = 1; m_pend = bt; end
                   else m_pend = m_pend || bt;
`else
                   e_tick = bt ? 1 : 0;
`endif
               end
            3: if (p1_wins || p2_wins) begin
                   m_win = p1_wins ? 1 : 2; m_hold = WH; m_st = 4;
               end else begin
                   e_rr = 1; m_hold = SRV; m_st = 1;
               end
            4: if (m_hold == 0) begin
                   e_mr = 1; e_rr = 1; m_win = 0; m_hold = SRV; m_st = 1;
               end else if (bt) m_hold--;
            default: if (!ps) m_st = m_org;
        endcase
        if (m_st != 2) m_pend = 0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        chk("model.state", 32'(game_state), 32'(m_st));
        chk("model.game_tick", 32'(game_tick), 32'(e_tick));
        chk("model.round_reset", 32'(round_reset), 32'(e_rr));
        chk("model.match_reset", 32'(match_reset), 32'(e_mr));
        chk("model.winner", 32'(winner), 32'(m_win));
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, ".state"}, 32'(game_state), 0);
        chk({pfx, ".game_tick"}, 32'(game_tick), 0);
        chk({pfx, ".round_reset"}, 32'(round_reset), 0);
        chk({pfx, ".match_reset"}, 32'(match_reset), 0);
        chk({pfx, ".winner"}, 32'(winner), 0);
    endtask

    typedef struct {
        int n;
        bit pz, s1, s2, w1, w2;
        int st, tk, rr, mr, wn;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t v(int n, bit pz, bit s1, bit s2, bit w1, bit w2,
                               int st, int tk, int rr, int mr, int wn);
        vec_t r;
        r.n = n; r.pz = pz; r.s1 = s1; r.s2 = s2; r.w1 = w1; r.w2 = w2;
        r.st = st; r.tk = tk; r.rr = rr; r.mr = mr; r.wn = wn;
        return r;
    endfunction

    initial begin
        int nticks;
        int tick_at_206;

        // Edge k after release sees divider value (k-1) % 10; base ticks at edges 10, 20, ...
        vt.push_back(v( 1, 0,0,0,0,0, 1,0,1,1,0));   // edge 1: release pulses
        vt.push_back(v( 1, 0,0,0,0,0, 1,0,0,0,0));
        vt.push_back(v(19, 0,0,0,0,0, 2,0,0,0,0));   // edge 21: serve done
        vt.push_back(v( 9, 0,0,0,0,0, 2,1,0,0,0));   // edge 30
        vt.push_back(v( 1, 0,0,0,0,0, 2,0,0,0,0));
        vt.push_back(v( 9, 0,0,0,0,0, 2,1,0,0,0));   // edge 40
        vt.push_back(v( 1, 0,0,1,0,0, 3,0,0,0,0));   // p2 point
        vt.push_back(v( 1, 0,0,0,0,0, 1,0,1,0,0));
        vt.push_back(v(19, 0,0,0,0,0, 2,0,0,0,0));   // edge 61
        vt.push_back(v( 1, 0,1,0,1,0, 3,0,0,0,0));   // p1 scores and wins
        vt.push_back(v( 1, 0,0,0,1,0, 4,0,0,0,1));
        vt.push_back(v(27, 0,0,0,1,0, 4,0,0,0,1));   // edge 90: still holding
        vt.push_back(v( 1, 0,0,0,0,0, 1,0,1,1,0));   // edge 91: match restart
        vt.push_back(v(20, 0,0,0,0,0, 2,0,0,0,0));   // edge 111
        vt.push_back(v( 3, 1,0,0,0,0, 5,0,0,0,0));   // edge 114: paused
        vt.push_back(v( 6, 1,0,0,0,0, 5,0,0,0,0));   // edge 120: tick suppressed
        vt.push_back(v( 3, 0,0,0,0,0, 2,0,0,0,0));   // edge 123: resumed
        vt.push_back(v( 7, 0,0,0,0,0, 2,1,0,0,0));   // edge 130: same phase
        vt.push_back(v( 1, 0,0,1,0,1, 3,0,0,0,0));
        vt.push_back(v( 1, 1,0,0,0,1, 4,0,0,0,2));
        vt.push_back(v(28, 1,0,0,0,1, 4,0,0,0,2));   // edge 160: pause ignored
        vt.push_back(v( 1, 1,0,0,0,0, 1,0,1,1,0));   // edge 161
        vt.push_back(v( 1, 1,0,0,0,0, 5,0,0,0,0));   // pause honoured in serve
        vt.push_back(v( 3, 0,0,0,0,0, 1,0,0,0,0));   // edge 165
        vt.push_back(v(16, 0,0,0,0,0, 2,0,0,0,0));   // edge 181: remaining count kept

        model_reset();
        #1 reset_n = 1'b0;
        #10;
        chk_zero("reset");
        #10 reset_n = 1'b1;

        foreach (vt[i]) begin
            pause = vt[i].pz; p1_wins = vt[i].w1; p2_wins = vt[i].w2;
            p1_scored = vt[i].s1; p2_scored = vt[i].s2;
            for (int k = 0; k < vt[i].n; k++) begin
                step();
                p1_scored = 1'b0; p2_scored = 1'b0;
            end
            chk($sformatf("vec%0d.state", i), 32'(game_state), 32'(vt[i].st));
            chk($sformatf("vec%0d.game_tick", i), 32'(game_tick), 32'(vt[i].tk));
            chk($sformatf("vec%0d.round_reset", i), 32'(round_reset), 32'(vt[i].rr));
            chk($sformatf("vec%0d.match_reset", i), 32'(match_reset), 32'(vt[i].mr));
            chk($sformatf("vec%0d.winner", i), 32'(winner), 32'(vt[i].wn));
        end

        // Frame sync: base ticks at edges 190 and 200, frame_end seen at edge 206.
        nticks = 0; tick_at_206 = 0;
        for (int k = 182; k <= 206; k++) begin
            frame_end = (k == 206);
            step();
            if (game_tick === 1'b1) nticks++;
            if (k == 206) tick_at_206 = (game_tick === 1'b1) ? 1 : 0;
        end
        frame_end = 1'b0;
`ifdef GAME_FRAME_SYNC_EN
        chk("fsync.tick_count", 32'(nticks), 1);
        chk("fsync.tick_after_frame_end", 32'(tick_at_206), 1);
`else
        chk("fsync.tick_count", 32'(nticks), 2);
        chk("fsync.tick_after_frame_end", 32'(tick_at_206), 0);
`endif

        // Randomised run against the model.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(39) == 0) pause = ~pause;
            if ($urandom_range(15) == 0) begin
                p1_wins = ($urandom_range(2) == 0);
                p2_wins = ($urandom_range(2) == 0);
            end
            p1_scored = ($urandom_range(29) == 0);
            p2_scored = ($urandom_range(29) == 0);
            frame_end = ($urandom_range(7) == 0);
            step();
        end

        // Reset mid win-hold must clear everything immediately.
        pause = 0; p1_scored = 0; p2_scored = 0; p1_wins = 0; p2_wins = 0; frame_end = 0;
        reset_n = 1'b0;
        model_reset();
        #1 chk_zero("rst_again");
        #3 reset_n = 1'b1;
        for (int k = 0; k < 21; k++) step();
        p1_scored = 1'b1; p1_wins = 1'b1;
        step();
        p1_scored = 1'b0;
        for (int k = 0; k < 5; k++) step();
        chk("midhold.state_before", 32'(game_state), 4);
        chk("midhold.winner_before", 32'(winner), 1);
        #2 reset_n = 1'b0;
        #1 chk_zero("midhold_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
